// File: rtl/hwregs_uart.sv
// hwregs_uart: hwregs window (seven-seg, LEDs, switches, keys) plus an 8N1 UART with TX/RX FIFOs.
// Define HWREGS_LOOPBACK_EN to add STATUS bit 8, which routes internal TX into RX and holds UART_TX high.
module hwregs_uart #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_LEDS   = 10,
  parameter int NUM_SW     = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cpud_request,
  input  logic [15:0]         cpud_addr,
  input  logic                cpud_write,
  input  logic [3:0]          cpud_byte_enable,
  input  logic [31:0]         cpud_wdata,
  output logic [31:0]         cpud_rdata,
  output logic                cpud_ack,
  output logic [23:0]         seven_seg_data,
  output logic [NUM_LEDS-1:0] LEDR,
  input  logic [NUM_SW-1:0]   SW,
  input  logic [3:0]          KEY,
  output logic                UART_TX,
  input  logic                UART_RX
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(DIV + 1);
  localparam logic [TW-1:0] T_END  = TW'(DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic rd_en, wr_en, a_seg, a_led, a_sw, a_key, a_tx, a_rx, a_st;
  logic [31:0] lane_m, rd_d;
  logic [23:0] seg_q;
  logic [NUM_LEDS-1:0] led_q;
  logic ovf_q, ferr_q, lb_bit, busy, rx_in, tx_q;
  logic [8:0] st;
  logic [7:0] txf_q [FIFO_DEPTH];
  logic [AW-1:0] txw_q, txr_q;
  logic [CW-1:0] txc_q;
  logic tx_push, tx_pop;
  state_t txs_q;
  logic [TW-1:0] txt_q;
  logic [2:0] txb_q;
  logic [7:0] txsh_q;
  logic [7:0] rxf_q [FIFO_DEPTH];
  logic [AW-1:0] rxw_q, rxr_q;
  logic [CW-1:0] rxc_q;
  logic rx_push, rx_pop;
  logic rx_s1_q, rx_s2_q, rx_s3_q, rxv_q, rxfe_q;
  state_t rxs_q;
  logic [TW-1:0] rxt_q;
  logic [2:0] rxb_q;
  logic [7:0] rxsh_q;
  logic unused_bits;
  assign rd_en  = cpud_request & ~cpud_write;
  assign wr_en  = cpud_request & cpud_write;
  assign a_seg  = cpud_addr == 16'h0000;
  assign a_led  = cpud_addr == 16'h0004;
  assign a_sw   = cpud_addr == 16'h0008;
  assign a_key  = cpud_addr == 16'h000C;
  assign a_tx   = cpud_addr == 16'h0010;
  assign a_rx   = cpud_addr == 16'h0014;
  assign a_st   = cpud_addr == 16'h0018;
  assign lane_m = {{8{cpud_byte_enable[3]}}, {8{cpud_byte_enable[2]}},
                   {8{cpud_byte_enable[1]}}, {8{cpud_byte_enable[0]}}};
  assign unused_bits = &{1'b0, cpud_wdata, lane_m};
  assign tx_push = wr_en & a_tx & cpud_byte_enable[0] & (txc_q != FULL);
  assign tx_pop  = (txs_q == IDLE) & (txc_q != '0);
  assign rx_push = rxv_q & (rxc_q != FULL);
  assign rx_pop  = rd_en & a_rx & (rxc_q != '0);
  assign busy    = (txs_q != IDLE) | (txc_q != '0);
  assign st      = {lb_bit, 4'b0, rxc_q != '0, busy, ferr_q, ovf_q};
  assign seven_seg_data = seg_q;
  assign LEDR = led_q;
`ifdef HWREGS_LOOPBACK_EN
  logic lb_q;
  assign lb_bit  = lb_q;
  assign rx_in   = lb_q ? tx_q : UART_RX;
  assign UART_TX = tx_q | lb_q;
  // Loopback control lives in STATUS lane 1
  always_ff @(posedge clock)
    lb_q <= reset ? 1'b0 : (wr_en & a_st & cpud_byte_enable[1]) ? cpud_wdata[8] : lb_q;
`else
  assign lb_bit  = 1'b0;
  assign rx_in   = UART_RX;
  assign UART_TX = tx_q;
`endif
  // Read mux; the empty RX check uses the pre-push count so a same-cycle receive is kept
  always_comb begin
    rd_d = '0;
    case (1'b1)
      a_seg: rd_d = {8'h0, seg_q};
      a_led: rd_d = 32'(led_q);
      a_sw:  rd_d = 32'(SW);
      a_key: rd_d = {28'h0, KEY};
      a_tx:  rd_d = 32'(FULL - txc_q);
      a_rx:  rd_d = (rxc_q == '0) ? 32'hFFFF_FFFF : {24'h0, rxf_q[rxr_q]};
      a_st:  rd_d = {23'h0, st};
      default: rd_d = '0;
    endcase
  end
  // Bus response one cycle after request; rdata is zero outside read acks
  always_ff @(posedge clock) begin
    cpud_ack   <= reset ? 1'b0 : cpud_request;
    cpud_rdata <= (reset | ~rd_en) ? '0 : rd_d;
  end
  // Byte-lane merged register writes and sticky status (a new error wins over a clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q  <= '0;
      led_q  <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (wr_en & a_seg) seg_q <= (seg_q & ~lane_m[23:0]) | (cpud_wdata[23:0] & lane_m[23:0]);
      if (wr_en & a_led) led_q <= (led_q & ~lane_m[NUM_LEDS-1:0]) | (cpud_wdata[NUM_LEDS-1:0] & lane_m[NUM_LEDS-1:0]);
      ovf_q  <= (ovf_q & ~(wr_en & a_st & cpud_byte_enable[0] & cpud_wdata[0])) | (rxv_q & (rxc_q == FULL));
      ferr_q <= (ferr_q & ~(wr_en & a_st & cpud_byte_enable[0] & cpud_wdata[1])) | rxfe_q;
    end
  end
  // FIFO storage (no reset needed, validity tracked by counts)
  always_ff @(posedge clock) begin
    if (tx_push) txf_q[txw_q] <= cpud_wdata[7:0];
    if (rx_push) rxf_q[rxw_q] <= rxsh_q;
  end
  // FIFO pointers and counts; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clock) begin
    if (reset) begin
      txw_q <= '0;
      txr_q <= '0;
      txc_q <= '0;
      rxw_q <= '0;
      rxr_q <= '0;
      rxc_q <= '0;
    end else begin
      txw_q <= txw_q + AW'(tx_push);
      txr_q <= txr_q + AW'(tx_pop);
      txc_q <= txc_q + CW'(tx_push) - CW'(tx_pop);
      rxw_q <= rxw_q + AW'(rx_push);
      rxr_q <= rxr_q + AW'(rx_pop);
      rxc_q <= rxc_q + CW'(rx_push) - CW'(rx_pop);
    end
  end
  // TX frame FSM: start, 8 data bits LSB first, stop, with a single IDLE cycle between frames
  always_ff @(posedge clock) begin
    if (reset) begin
      txs_q  <= IDLE;
      tx_q   <= 1'b1;
      txt_q  <= '0;
      txb_q  <= '0;
      txsh_q <= '0;
    end else begin
      case (txs_q)
        IDLE: if (tx_pop) begin
          txs_q  <= START;
          tx_q   <= 1'b0;
          txsh_q <= txf_q[txr_q];
          txt_q  <= '0;
        end
        START: if (txt_q == T_END) begin
          txs_q <= DATA;
          tx_q  <= txsh_q[0];
          txb_q <= '0;
          txt_q <= '0;
        end else txt_q <= txt_q + TW'(1);
        DATA: if (txt_q == T_END) begin
          txt_q  <= '0;
          txsh_q <= txsh_q >> 1;
          if (txb_q == 3'd7) begin
            txs_q <= STOP;
            tx_q  <= 1'b1;
          end else begin
            txb_q <= txb_q + 3'd1;
            tx_q  <= txsh_q[1];
          end
        end else txt_q <= txt_q + TW'(1);
        default: if (txt_q == T_END) begin
          txs_q <= IDLE;
          txt_q <= '0;
        end else txt_q <= txt_q + TW'(1);
      endcase
    end
  end
  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clock) begin
    rx_s1_q <= reset | rx_in;
    rx_s2_q <= reset | rx_s1_q;
    rx_s3_q <= reset | rx_s2_q;
  end
  // RX frame FSM: mid-bit sampling, glitch rejection on start, one-cycle push/error pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      rxs_q  <= IDLE;
      rxt_q  <= '0;
      rxb_q  <= '0;
      rxsh_q <= '0;
      rxv_q  <= 1'b0;
      rxfe_q <= 1'b0;
    end else begin
      rxv_q  <= 1'b0;
      rxfe_q <= 1'b0;
      case (rxs_q)
        IDLE: if (rx_s3_q & ~rx_s2_q) begin
          rxs_q <= START;
          rxt_q <= '0;
        end
        START: if (rxt_q == T_HALF) begin
          rxs_q <= rx_s2_q ? IDLE : DATA;
          rxt_q <= '0;
          rxb_q <= '0;
        end else rxt_q <= rxt_q + TW'(1);
        DATA: if (rxt_q == T_END) begin
          rxt_q  <= '0;
          rxsh_q <= {rx_s2_q, rxsh_q[7:1]};
          rxs_q  <= (rxb_q == 3'd7) ? STOP : DATA;
          rxb_q  <= rxb_q + 3'd1;
        end else rxt_q <= rxt_q + TW'(1);
        default: if (rxt_q == T_END) begin
          rxs_q  <= IDLE;
          rxt_q  <= '0;
          rxv_q  <= rx_s2_q;
          rxfe_q <= ~rx_s2_q;
        end else rxt_q <= rxt_q + TW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_hwregs_uart.sv
// tb_hwregs_uart: scoreboard bench for hwregs_uart at 50 MHz / 3 Mbaud, so DIV = (50e6+1.5e6)/3e6 = 17.
module tb_hwregs_uart;
  localparam int DIV = 17;
  logic clock = 1'b0, reset = 1'b1, req = 1'b0, wr = 1'b0, urx = 1'b1;
  logic [15:0] addr = '0;
  logic [3:0] be = '0;
  logic [31:0] wdata = '0, rdata;
  logic ack, utx;
  logic [23:0] seg;
  logic [9:0] ledr;
  logic [9:0] sw = 10'h2A5;
  logic [3:0] key = 4'hA;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e, r;
  bit a;

  hwregs_uart #(.CLK_FREQ(50000000), .BAUD(3000000), .FIFO_DEPTH(16), .NUM_LEDS(10), .NUM_SW(10)) dut (
    .clock(clock), .reset(reset), .cpud_request(req), .cpud_addr(addr), .cpud_write(wr),
    .cpud_byte_enable(be), .cpud_wdata(wdata), .cpud_rdata(rdata), .cpud_ack(ack),
    .seven_seg_data(seg), .LEDR(ledr), .SW(sw), .KEY(key), .UART_TX(utx), .UART_RX(urx));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus(input logic [15:0] ad, input logic w, input logic [3:0] b, input logic [31:0] d,
                     output logic [31:0] rd, output bit ak);
    @(negedge clock);
    req = 1'b1; addr = ad; wr = w; be = b; wdata = d;
    @(negedge clock);
    req = 1'b0; wr = 1'b0; be = '0;
    rd = rdata; ak = ack;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      urx = f[i];
      repeat (DIV) @(negedge clock);
    end
    urx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset;
    logic [15:0] ra [5];
    ra = '{16'h00, 16'h04, 16'h10, 16'h18, 16'h14};
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if (utx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", utx); end
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'd16);
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      bus(ra[i], 1'b0, 4'h0, '0, r, a);
      e = exp_q.pop_front();
      n_cmp += 2;
      if (r !== e) begin n_bad++; $display("FAIL reset_read %h: got %h want %h", ra[i], r, e); end
      if (a !== 1'b1) begin n_bad++; $display("FAIL reset_ack %h: got %b want 1", ra[i], a); end
    end
    @(negedge clock);
    n_cmp++;
    if ({ack, rdata} !== 33'h0) begin n_bad++; $display("FAIL idle_bus: got ack %b rdata %h want 0/0", ack, rdata); end
  endtask

  task automatic test_registers;
    logic [15:0] ra [7];
    bus(16'h00, 1'b1, 4'b0101, 32'hAABBCCDD, r, a);
    bus(16'h04, 1'b1, 4'b1111, 32'hFFFFFFFF, r, a);
    n_cmp += 2;
    if (seg !== 24'hBB00DD) begin n_bad++; $display("FAIL seg_port: got %h want bb00dd", seg); end
    if (ledr !== 10'h3FF) begin n_bad++; $display("FAIL ledr_port: got %h want 3ff", ledr); end
    bus(16'h1C, 1'b1, 4'b1111, 32'hFFFFFFFF, r, a);
    ra = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h1C, 16'h04, 16'h00};
    exp_q.push_back(32'h00BB00DD); exp_q.push_back(32'h3FF); exp_q.push_back(32'h2A5);
    exp_q.push_back(32'hA); exp_q.push_back(32'h0); exp_q.push_back(32'h300); exp_q.push_back(32'h00BB00DD);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) bus(16'h04, 1'b1, 4'b0001, 32'h0, r, a);
      bus(ra[i], 1'b0, 4'h0, '0, r, a);
      e = exp_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL reg_read %0d @%h: got %h want %h", i, ra[i], r, e); end
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input string nm);
    logic [9:0] f;
    bit bad;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) exp_q.push_back({31'h0, f[i]});
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      bad = 1'b0;
      for (int c = 0; c < DIV; c++) begin
        if (utx !== e[0]) bad = 1'b1;
        @(negedge clock);
      end
      n_cmp++;
      if (bad) begin n_bad++; $display("FAIL %s bit%0d: got %b want %b for %0d cycles", nm, i, utx, e[0], DIV); end
    end
  endtask

  task automatic test_tx;
    bit found;
    bus(16'h10, 1'b1, 4'b0010, 32'h99, r, a);
    exp_q.push_back(32'd16);
    bus(16'h10, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL tx_lane0: got %0d want %0d", r, e); end
    bus(16'h10, 1'b1, 4'b0001, 32'h55, r, a);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (utx === 1'b0) found = 1'b1;
      else @(negedge clock);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL tx_start: got no start bit want one"); end
    check_frame(8'h55, "tx55");
    n_cmp++;
    if (utx !== 1'b1) begin n_bad++; $display("FAIL tx_idle: got %b want 1", utx); end
    exp_q.push_back(32'd16); exp_q.push_back(32'h0);
    bus(16'h10, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL tx_free: got %0d want %0d", r, e); end
    bus(16'h18, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL tx_status: got %h want %h", r, e); end
  endtask

  task automatic test_back_to_back;
    int hc;
    bus(16'h10, 1'b1, 4'b0001, 32'h00, r, a);
    bus(16'h10, 1'b1, 4'b0001, 32'hA5, r, a);
    exp_q.push_back(32'd15); exp_q.push_back(32'h4);
    bus(16'h10, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL b2b_free: got %0d want %0d", r, e); end
    bus(16'h18, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL b2b_busy: got %h want %h", r, e); end
    for (int i = 0; i < 12 * DIV && utx !== 1'b1; i++) @(negedge clock);
    hc = 0;
    while (utx === 1'b1 && hc < 3 * DIV) begin
      hc++;
      @(negedge clock);
    end
    n_cmp++;
    if (hc != DIV + 1) begin n_bad++; $display("FAIL b2b_gap: got %0d high cycles want %0d", hc, DIV + 1); end
    check_frame(8'hA5, "b2b_a5");
  endtask

  task automatic test_rx;
    logic [15:0] ra [4];
    send_rx(8'hA3, 1'b1);
    ra = '{16'h18, 16'h14, 16'h14, 16'h18};
    exp_q.push_back(32'h8); exp_q.push_back(32'hA3); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus(ra[i], 1'b0, 4'h0, '0, r, a);
      e = exp_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL rx_read %0d @%h: got %h want %h", i, ra[i], r, e); end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    exp_q.push_back(32'h9);
    for (int k = 0; k < 17; k++) begin
      b = 8'(k * 13 + 5);
      if (k < 16) exp_q.push_back({24'h0, b});
      send_rx(b, 1'b1);
    end
    exp_q.push_back(32'hFFFF_FFFF);
    bus(16'h18, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL ovf_status: got %h want %h", r, e); end
    for (int k = 0; k < 17; k++) begin
      bus(16'h14, 1'b0, 4'h0, '0, r, a);
      e = exp_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL ovf_data %0d: got %h want %h", k, r, e); end
    end
    bus(16'h18, 1'b1, 4'b0001, 32'h1, r, a);
    exp_q.push_back(32'h0);
    bus(16'h18, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL ovf_clear: got %h want %h", r, e); end
  endtask

  task automatic test_framing;
    logic [15:0] ra [3];
    send_rx(8'h5A, 1'b0);
    ra = '{16'h18, 16'h14, 16'h18};
    exp_q.push_back(32'h2); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus(16'h18, 1'b1, 4'b0001, 32'h2, r, a);
      bus(ra[i], 1'b0, 4'h0, '0, r, a);
      e = exp_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL frame_read %0d @%h: got %h want %h", i, ra[i], r, e); end
    end
  endtask

  task automatic test_midframe_reset;
    bus(16'h10, 1'b1, 4'b0001, 32'h00, r, a);
    for (int i = 0; i < 10 && utx !== 1'b0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    n_cmp++;
    if (utx !== 1'b0) begin n_bad++; $display("FAIL mid_low: got %b want 0", utx); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp += 3;
    if (utx !== 1'b1) begin n_bad++; $display("FAIL mid_reset_tx: got %b want 1", utx); end
    if (seg !== 24'h0) begin n_bad++; $display("FAIL mid_reset_seg: got %h want 0", seg); end
    if (ledr !== 10'h0) begin n_bad++; $display("FAIL mid_reset_ledr: got %h want 0", ledr); end
    exp_q.push_back(32'd16);
    bus(16'h10, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL mid_reset_free: got %0d want %0d", r, e); end
  endtask

`ifdef HWREGS_LOOPBACK_EN
  task automatic test_loopback;
    bit hi;
    bus(16'h18, 1'b1, 4'b0010, 32'h100, r, a);
    exp_q.push_back(32'h100);
    bus(16'h18, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL lb_ctrl: got %h want %h", r, e); end
    exp_q.push_back(32'h3C);
    bus(16'h10, 1'b1, 4'b0001, 32'h3C, r, a);
    hi = 1'b1;
    repeat (12 * DIV) begin
      if (utx !== 1'b1) hi = 1'b0;
      @(negedge clock);
    end
    n_cmp++;
    if (!hi) begin n_bad++; $display("FAIL lb_tx_high: got a low UART_TX want constant 1"); end
    bus(16'h14, 1'b0, 4'h0, '0, r, a);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL lb_data: got %h want %h", r, e); end
    bus(16'h18, 1'b1, 4'b0010, 32'h0, r, a);
  endtask
`endif

  initial begin
    test_reset();
    test_registers();
    test_tx();
    test_back_to_back();
    test_rx();
    test_overflow();
    test_framing();
    test_midframe_reset();
`ifdef HWREGS_LOOPBACK_EN
    test_loopback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hwregs_uart.md
Name: hwregs_uart

Overview:
Parametrised successor to the memory-mapped hardware register block at 0xE0000000. It serves the 64 KB hwregs window on the CPU data bus. The block provides the seven-segment, LED, switch and key registers, widened by parameters. It adds a working 8N1 UART with TX and RX FIFOs and a sticky status register.

Parameters:
CLK_FREQ, 50000000, clock frequency in Hz.
BAUD, 115200, UART bit rate. Divider DIV = (CLK_FREQ + BAUD/2) / BAUD, which is 434 at the defaults.
FIFO_DEPTH, 16, entries in each UART FIFO. Must be a power of 2 and at least 2.
NUM_LEDS, 10, LEDR width. Range 1..32.
NUM_SW, 10, SW width. Range 1..32.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpud_request  in  1  one-cycle bus request
cpud_addr  in  16  byte offset within the window
cpud_write  in  1  1 = write, 0 = read
cpud_byte_enable  in  4  write byte lanes
cpud_wdata  in  32  write data
cpud_rdata  out  32  read data
cpud_ack  out  1  response strobe
seven_seg_data  out  24  six hex nibbles, to the seven_seg decoder
LEDR  out  NUM_LEDS  LEDs
SW  in  NUM_SW  switches (synchronous to clock)
KEY  in  4  push buttons (synchronous to clock)
UART_TX  out  1  serial out, idle high
UART_RX  in  1  serial in, asynchronous

Behaviour:
- Clock and reset: clock is clock; reset is reset, synchronous, active-high.
- Reset values:
  - cpud_ack = 0, cpud_rdata = 0.
  - seven_seg_data = 0, LEDR = 0, UART_TX = 1.
  - Both FIFOs empty, status bits 0, both UART FSMs in IDLE.
- Reset mid-frame aborts the frame immediately. UART_TX returns high the next cycle.
- Bus timing:
  - cpud_ack is asserted exactly 1 cycle after cpud_request.
  - cpud_rdata is valid in the ack cycle and is 0 in every other cycle.
  - Reads of unmapped offsets return 0. Writes to unmapped offsets are ignored.
- Byte-lane rule: register writes update only the lanes enabled in cpud_byte_enable. A UART_TX push requires lane 0.
- Register map:
  - 0x00 SEVEN_SEG, R/W, bits 23:0.
  - 0x04 LEDR, R/W, bits NUM_LEDS-1:0. Upper bits read 0.
  - 0x08 SW, R, zero-extended.
  - 0x0C KEY, R, zero-extended.
  - 0x10 UART_TX. Write pushes wdata[7:0]; a push when the FIFO is full is dropped silently. Read returns the number of free slots (0..FIFO_DEPTH).
  - 0x14 UART_RX. Read pops and returns the byte zero-extended, or 0xFFFFFFFF when the FIFO is empty. Writes are ignored.
  - 0x18 STATUS. Bit0 = RX overflow (sticky), bit1 = framing error (sticky), bit2 = TX busy, bit3 = RX data available. Writing 1 to bit0 or bit1 clears that bit.
- FIFOs:
  - Circular, with a count of width clog2(FIFO_DEPTH)+1.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - A read of an empty RX FIFO returns 0xFFFFFFFF even if the receiver pushes in that same cycle. That byte is retained for the next read.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when the FIFO is not empty, pop one byte and enter START.
  - Each bit is held for DIV cycles. Data is sent LSB first. The stop bit is 1.
  - Back-to-back bytes: IDLE lasts exactly 1 cycle between frames.
  - TX busy = state != IDLE, or FIFO not empty.
- RX path:
  - UART_RX passes through a 2-flop synchroniser.
  - FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a 1 -> 0 edge enters START. Sample at DIV/2; if the line is high again, treat it as a glitch and return to IDLE.
  - DATA: 8 samples at DIV intervals, LSB first.
  - STOP: sample at DIV. If the stop bit is 0, set the framing error, discard the byte and return to IDLE. Otherwise push the byte.
  - A push into a full FIFO sets overflow and discards the new byte; existing data is preserved.
  - A status clear and a new error in the same cycle leave the bit set.

Optional Feature:
- Macro: HWREGS_LOOPBACK_EN.
- Defined:
  - STATUS bit 8 is a R/W loopback control, reset 0.
  - When it is set, the RX synchroniser input is the internal TX serial line and UART_TX is held at 1.
  - The switch takes effect the next cycle.
- Undefined: bit 8 reads 0 and writes to it are ignored. No mux logic is present.

Test Plan:
1. Reset, then read 0x00/0x04/0x10/0x14/0x18 -> 0, 0, 16, 0xFFFFFFFF, 0. UART_TX = 1. Each ack arrives 1 cycle after its request.
2. Write 0x00 with 0xAABBCCDD, be=0101; write 0x04 with 0xFFFFFFFF, be=1111 -> SEVEN_SEG reads 0x00BB00DD. LEDR = 0x3FF. 0x04 reads 0x000003FF.
3. Push 0x55 to 0x10 -> UART_TX waveform is low for 434 cycles, then 1,0,1,0,1,0,1,0 each 434 cycles, then high. 0x10 reads 15 until the pop, then 16.
4. Drive UART_RX with byte 0xA3 at 115200 baud -> 0x18 bit3 = 1. Read 0x14 -> 0x000000A3, then 0xFFFFFFFF.
5. Drive 17 RX bytes with no reads -> overflow bit0 = 1. The first 16 bytes read back in order. Write 0x1 to 0x18 -> bit0 = 0.
6. RX frame with stop bit 0 -> bit1 = 1 and the FIFO stays empty. With HWREGS_LOOPBACK_EN defined, set bit 8 and push 0x3C -> read 0x14 returns 0x3C, and UART_TX stays at 1 throughout.
